// File: rtl/subcounter_pkg.sv
// subcounter_pkg: shared definitions for the subcounter slice.
//   sub_cmd_t               - 2-bit command broadcast by the fabric controller
//   SUB_GRANULARITY_DEFAULT - default slice width in bits
package subcounter_pkg;

  typedef enum logic [1:0] {
    SUB_CLEAR = 2'b00,
    SUB_INC   = 2'b01,
    SUB_HOLD  = 2'b10,
    SUB_LOAD  = 2'b11
  } sub_cmd_t;

  localparam int SUB_GRANULARITY_DEFAULT = 4;

endpackage : subcounter_pkg

// File: rtl/subcounter_decode.sv
// subcounter_decode: turns the 2-bit command into one-hot strobes.
// Ports:
//   cmd   - command (sub_cmd_t)
//   clear - CLEAR strobe
//   inc   - INCREMENT strobe
//   load  - LOAD strobe
// HOLD raises no strobe.
module subcounter_decode
  import subcounter_pkg::*;
(
  input  sub_cmd_t cmd,
  output logic     clear,
  output logic     inc,
  output logic     load
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a signal unassigned, which would infer a latch.
    clear = 1'b0;
    inc   = 1'b0;
    load  = 1'b0;
    unique case (cmd)
      SUB_CLEAR: clear = 1'b1;
      SUB_INC:   inc   = 1'b1;
      SUB_LOAD:  load  = 1'b1;
      SUB_HOLD:  ;
      default:   ;
    endcase
  end

endmodule : subcounter_decode

// File: rtl/subcounter.sv
// subcounter: one granularity-bit slice of the shared-counter fabric.
// Slices chain through carry_in/carry_out; the LSB slice ties carry_in high.
// Ports:
//   clk            - rising-edge clock
//   rst            - synchronous active-high reset, priority over commands
//   sub_command_in - 00 CLEAR, 01 INCREMENT, 10 HOLD, 11 LOAD
//   carry_in       - increment enable from the lower slice
//   load_in        - value written by LOAD
//   data_out       - registered counter value
//   carry_out      - combinational wrap indication to the next slice
//   overflow_out   - sticky wrap flag, only when SUBCOUNTER_OVF_EN is defined
// Configuration macro: SUBCOUNTER_OVF_EN (adds overflow_out and its register).
module subcounter
  import subcounter_pkg::*;
#(
  parameter int granularity = SUB_GRANULARITY_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             sub_command_in,
  input  logic                   carry_in,
  input  logic [granularity-1:0] load_in,
  output logic [granularity-1:0] data_out,
  output logic                   carry_out
`ifdef SUBCOUNTER_OVF_EN
  ,
  output logic                   overflow_out
`endif
);

  logic clear;
  logic inc;
  logic load;

  subcounter_decode u_decode (
    .cmd   (sub_cmd_t'(sub_command_in)),
    .clear (clear),
    .inc   (inc),
    .load  (load)
  );

  // Wrap happens only when this slice is enabled to count and is at all ones.
  assign carry_out = inc && carry_in && (data_out == '1);

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      data_out <= '0;
    end else if (clear) begin
      data_out <= '0;
    end else if (load) begin
      data_out <= load_in;
    end else if (inc && carry_in) begin
      data_out <= data_out + granularity'(1);
    end
  end

`ifdef SUBCOUNTER_OVF_EN
  // Sticky: set on a wrapping increment, dropped only by reset or CLEAR.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      overflow_out <= 1'b0;
    end else if (carry_out) begin
      overflow_out <= 1'b1;
    end
  end
`endif

endmodule : subcounter

// File: tb/tb_subcounter.sv
// tb_subcounter: directed self-checking bench for subcounter (granularity 4).
// Overflow checks are active when SUBCOUNTER_OVF_EN is defined.
module tb_subcounter;

  localparam logic [1:0] C_CLEAR = 2'b00;
  localparam logic [1:0] C_INC   = 2'b01;
  localparam logic [1:0] C_HOLD  = 2'b10;
  localparam logic [1:0] C_LOAD  = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] sub_command_in = C_HOLD;
  logic       carry_in = 1'b1;
  logic [3:0] load_in = 4'h0;
  logic [3:0] data_out;
  logic       carry_out;
`ifdef SUBCOUNTER_OVF_EN
  logic       overflow_out;
`endif

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  subcounter #(.granularity(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .sub_command_in (sub_command_in),
    .carry_in       (carry_in),
    .load_in        (load_in),
    .data_out       (data_out),
    .carry_out      (carry_out)
`ifdef SUBCOUNTER_OVF_EN
    ,
    .overflow_out   (overflow_out)
`endif
  );

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; sub_command_in = C_LOAD; load_in = 4'hF; carry_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (data_out !== 4'h0) $display("FAIL reset_data cyc%0d: got %h want 0", i, data_out);
      else passes++;
      checks++;
      if (carry_out !== 1'b0) $display("FAIL reset_carry cyc%0d: got %b want 0", i, carry_out);
      else passes++;
    end
`ifdef SUBCOUNTER_OVF_EN
    checks++;
    if (overflow_out !== 1'b0) $display("FAIL reset_ovf: got %b want 0", overflow_out);
    else passes++;
`endif
    rst = 1'b0;
  endtask

  task automatic test_clear_inc();
    sub_command_in = C_CLEAR;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (data_out !== 4'h0) $display("FAIL clear cyc%0d: got %h want 0", i, data_out);
      else passes++;
    end
    sub_command_in = C_INC; carry_in = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      checks++;
      if (carry_out !== 1'b0) $display("FAIL inc_carry step%0d: got %b want 0", i, carry_out);
      else passes++;
      tick();
      checks++;
      if (data_out !== 4'(i)) $display("FAIL inc step%0d: got %h want %h", i, data_out, 4'(i));
      else passes++;
    end
  endtask

  task automatic test_hold();
    sub_command_in = C_HOLD;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (data_out !== 4'hA) $display("FAIL hold cyc%0d: got %h want a", i, data_out);
      else passes++;
    end
  endtask

  task automatic test_wrap();
    sub_command_in = C_LOAD; load_in = 4'hE;
    tick();
    checks++;
    if (data_out !== 4'hE) $display("FAIL load_e: got %h want e", data_out);
    else passes++;
    sub_command_in = C_INC; carry_in = 1'b1;
    checks++;
    if (carry_out !== 1'b0) $display("FAIL carry_at_e: got %b want 0", carry_out);
    else passes++;
    tick();
    checks++;
    if (data_out !== 4'hF) $display("FAIL inc_to_f: got %h want f", data_out);
    else passes++;
    // All ones but not INCREMENT: no carry.
    sub_command_in = C_HOLD; #1;
    checks++;
    if (carry_out !== 1'b0) $display("FAIL carry_f_hold: got %b want 0", carry_out);
    else passes++;
    sub_command_in = C_INC; #1;
    checks++;
    if (carry_out !== 1'b1) $display("FAIL carry_f_inc: got %b want 1", carry_out);
    else passes++;
`ifdef SUBCOUNTER_OVF_EN
    checks++;
    if (overflow_out !== 1'b0) $display("FAIL ovf_before_wrap: got %b want 0", overflow_out);
    else passes++;
`endif
    tick();
    checks++;
    if (data_out !== 4'h0) $display("FAIL wrap_to_0: got %h want 0", data_out);
    else passes++;
    checks++;
    if (carry_out !== 1'b0) $display("FAIL carry_after_wrap: got %b want 0", carry_out);
    else passes++;
`ifdef SUBCOUNTER_OVF_EN
    checks++;
    if (overflow_out !== 1'b1) $display("FAIL ovf_set: got %b want 1", overflow_out);
    else passes++;
    sub_command_in = C_LOAD; load_in = 4'h3;
    tick();
    checks++;
    if (overflow_out !== 1'b1) $display("FAIL ovf_sticky_load: got %b want 1", overflow_out);
    else passes++;
    sub_command_in = C_CLEAR;
    tick();
    checks++;
    if (overflow_out !== 1'b0) $display("FAIL ovf_clear: got %b want 0", overflow_out);
    else passes++;
`endif
  endtask

  task automatic test_carry_gating();
    logic       ci_seq [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] exp_seq[4] = '{4'h5, 4'h6, 4'h6, 4'h7};
    sub_command_in = C_LOAD; load_in = 4'h5;
    tick();
    sub_command_in = C_INC;
    for (int i = 0; i < 4; i++) begin
      carry_in = ci_seq[i]; #1;
      checks++;
      if (carry_out !== 1'b0) $display("FAIL gate_carry step%0d: got %b want 0", i, carry_out);
      else passes++;
      tick();
      checks++;
      if (data_out !== exp_seq[i]) $display("FAIL gate step%0d: got %h want %h", i, data_out, exp_seq[i]);
      else passes++;
    end
    carry_in = 1'b1;
  endtask

  task automatic test_reset_mid_count();
    sub_command_in = C_LOAD; load_in = 4'h9;
    tick();
    checks++;
    if (data_out !== 4'h9) $display("FAIL load_9: got %h want 9", data_out);
    else passes++;
    sub_command_in = C_INC; rst = 1'b1;
    tick();
    checks++;
    if (data_out !== 4'h0) $display("FAIL rst_mid: got %h want 0", data_out);
    else passes++;
    rst = 1'b0;
    tick();
    checks++;
    if (data_out !== 4'h1) $display("FAIL post_rst_inc: got %h want 1", data_out);
    else passes++;
  endtask

  // Back-to-back mixed commands, one per edge.
  task automatic test_back_to_back();
    logic [1:0] cmd_seq[5] = '{C_LOAD, C_INC, C_CLEAR, C_INC, C_LOAD};
    logic [3:0] ld_seq [5] = '{4'hC, 4'h0, 4'h0, 4'h0, 4'h2};
    logic [3:0] exp_seq[5] = '{4'hC, 4'hD, 4'h0, 4'h1, 4'h2};
    carry_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sub_command_in = cmd_seq[i]; load_in = ld_seq[i];
      tick();
      checks++;
      if (data_out !== exp_seq[i]) $display("FAIL b2b step%0d: got %h want %h", i, data_out, exp_seq[i]);
      else passes++;
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_clear_inc();
    test_hold();
    test_wrap();
    test_carry_gating();
    test_reset_mid_count();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule : tb_subcounter
